// File: rtl/qcl_pipe_flow_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : qcl_pipe_flow_ctrl
// Purpose : Credit-based valid/ready wrapper around a fixed-latency pipe,
//           with a skid FIFO that catches the pipe output.
// Rev     : 1.0  initial release
// ============================================================================
module qcl_pipe_flow_ctrl #(
  parameter int width_p  = 32,
  parameter int stages_p = 4,
  parameter int els_p    = 8
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       v_i,
  input  logic [width_p-1:0]         data_i,
  output logic                       ready_o,
  output logic [width_p-1:0]         pipe_d_o,
  output logic                       pipe_v_o,
  input  logic [width_p-1:0]         pipe_d_i,
  output logic                       v_o,
  output logic [width_p-1:0]         data_o,
  input  logic                       yumi_i,
  output logic [$clog2(els_p+1)-1:0] count_o
);

  localparam int                 c_cnt_w = $clog2(els_p + 1);
  localparam int                 c_ptr_w = (els_p > 1) ? $clog2(els_p) : 1;
  localparam logic [c_cnt_w-1:0] c_els   = c_cnt_w'(els_p);
  localparam logic [c_ptr_w-1:0] c_last  = c_ptr_w'(els_p - 1);

  logic                w_fire;
  logic                w_wr;
  logic                w_rd;
  logic [stages_p-1:0] r_vld;
  logic [c_cnt_w-1:0]  r_count;
  logic [c_cnt_w-1:0]  r_occ;
  logic [c_ptr_w-1:0]  r_wptr;
  logic [c_ptr_w-1:0]  r_rptr;
  logic [width_p-1:0]  r_mem [els_p];

  // Credits cover every beat in flight, so admission never needs yumi_i.
  assign ready_o  = !reset_i && (r_count < c_els);
  assign w_fire   = v_i & ready_o;
  assign pipe_d_o = data_i;
  assign pipe_v_o = w_fire;
  assign w_wr     = r_vld[stages_p-1];
  assign v_o      = (r_occ != '0);
  assign w_rd     = yumi_i & v_o;
  assign data_o   = r_mem[r_rptr];
  assign count_o  = r_count;

  generate
    if (stages_p == 1) begin : g_vld_single
      always_ff @(posedge clk_i) begin
        if (reset_i) r_vld <= '0;
        else         r_vld <= w_fire;
      end
    end else begin : g_vld_multi
      always_ff @(posedge clk_i) begin
        if (reset_i) r_vld <= '0;
        else         r_vld <= {r_vld[stages_p-2:0], w_fire};
      end
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_occ   <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= (r_wptr == c_last) ? '0 : r_wptr + 1'b1;
      if (w_rd) r_rptr <= (r_rptr == c_last) ? '0 : r_rptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
      case ({w_fire, yumi_i})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; only slots marked valid are ever read.
  always_ff @(posedge clk_i) begin
    if (w_wr) r_mem[r_wptr] <= pipe_d_i;
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (reset_i)
    !(w_wr && (r_occ == c_els)));
  a_no_underflow: assert property (@(posedge clk_i) disable iff (reset_i)
    !(yumi_i && !v_o));

endmodule
`default_nettype wire

// File: tb/tb_qcl_pipe_flow_ctrl.sv
`default_nettype none
// tb_qcl_pipe_flow_ctrl: scoreboard bench for three flow-controller configurations
// (4 stages/8 entries, 2 stages/6 entries, 4 stages/2 entries).
module tb_qcl_pipe_flow_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- DUT A: stages 4, els 8 ----------------
  logic        a_v = 1'b0, a_yumi_man = 1'b0, a_stream = 1'b0;
  logic [31:0] a_data = '0;
  logic        a_ready, a_pv, a_vo, a_yumi;
  logic [31:0] a_pd, a_do, a_pipe [4];
  logic [3:0]  a_count;
  assign a_yumi = a_stream ? a_vo : a_yumi_man;
  always @(posedge clk) begin
    a_pipe[0] <= a_pd; a_pipe[1] <= a_pipe[0]; a_pipe[2] <= a_pipe[1]; a_pipe[3] <= a_pipe[2];
  end
  qcl_pipe_flow_ctrl #(.width_p(32), .stages_p(4), .els_p(8)) u_a (
    .clk_i(clk), .reset_i(rst), .v_i(a_v), .data_i(a_data), .ready_o(a_ready),
    .pipe_d_o(a_pd), .pipe_v_o(a_pv), .pipe_d_i(a_pipe[3]), .v_o(a_vo),
    .data_o(a_do), .yumi_i(a_yumi), .count_o(a_count));

  // ---------------- DUT B: stages 2, els 6 ----------------
  logic        b_v = 1'b0, b_yr = 1'b0;
  logic [31:0] b_data = '0;
  logic        b_ready, b_pv, b_vo, b_yumi;
  logic [31:0] b_pd, b_do, b_pipe [2];
  logic [2:0]  b_count;
  assign b_yumi = b_yr & b_vo;
  always @(posedge clk) begin
    b_pipe[0] <= b_pd; b_pipe[1] <= b_pipe[0];
  end
  qcl_pipe_flow_ctrl #(.width_p(32), .stages_p(2), .els_p(6)) u_b (
    .clk_i(clk), .reset_i(rst), .v_i(b_v), .data_i(b_data), .ready_o(b_ready),
    .pipe_d_o(b_pd), .pipe_v_o(b_pv), .pipe_d_i(b_pipe[1]), .v_o(b_vo),
    .data_o(b_do), .yumi_i(b_yumi), .count_o(b_count));

  // ---------------- DUT C: stages 4, els 2 ----------------
  logic        c_v = 1'b0, c_win = 1'b0;
  logic [31:0] c_data = '0;
  logic        c_ready, c_pv, c_vo, c_yumi;
  logic [31:0] c_pd, c_do, c_pipe [4];
  logic [1:0]  c_count;
  assign c_yumi = c_vo;
  always @(posedge clk) begin
    c_pipe[0] <= c_pd; c_pipe[1] <= c_pipe[0]; c_pipe[2] <= c_pipe[1]; c_pipe[3] <= c_pipe[2];
  end
  qcl_pipe_flow_ctrl #(.width_p(32), .stages_p(4), .els_p(2)) u_c (
    .clk_i(clk), .reset_i(rst), .v_i(c_v), .data_i(c_data), .ready_o(c_ready),
    .pipe_d_o(c_pd), .pipe_v_o(c_pv), .pipe_d_i(c_pipe[3]), .v_o(c_vo),
    .data_o(c_do), .yumi_i(c_yumi), .count_o(c_count));

  // ---------------- scoreboards / monitors (sampled on negedge) ----------------
  logic        mon = 1'b0;
  logic [31:0] sb_a[$], sb_b[$], sb_c[$];
  int m_a_count = 0, m_b_count = 0, m_c_count = 0;
  int a_pops = 0, a_first_pop = -1, a_last_pop = 0, a_max_cnt = 0;
  int b_recv = 0, c_fires = 0;
  logic       b_both_pend = 1'b0;
  logic [2:0] b_both_cnt = '0;

  always @(negedge clk) if (mon) begin
    check("a_count", a_count, m_a_count);
    check("a_ready", a_ready, (!rst && m_a_count < 8));
    if (a_v && a_ready) sb_a.push_back(a_data);
    if (a_yumi && a_vo) begin
      check("a_sb_nonempty", (sb_a.size() != 0), 1);
      if (sb_a.size() != 0) check("a_data", a_do, sb_a.pop_front());
      a_pops++;
      if (a_first_pop < 0) a_first_pop = cyc;
      a_last_pop = cyc;
    end
    if (int'(a_count) > a_max_cnt) a_max_cnt = int'(a_count);
    if (rst) begin m_a_count = 0; sb_a.delete(); end
    else m_a_count = m_a_count + int'(a_v && a_ready) - int'(a_yumi);

    check("b_count", b_count, m_b_count);
    if (b_both_pend) check("b_count_fire_yumi", b_count, b_both_cnt);
    b_both_pend = b_v && b_ready && b_yumi;
    b_both_cnt  = b_count;
    if (b_v && b_ready) sb_b.push_back(b_data);
    if (b_yumi) begin
      check("b_sb_nonempty", (sb_b.size() != 0), 1);
      if (sb_b.size() != 0) check("b_data", b_do, sb_b.pop_front());
      b_recv++;
    end
    if (rst) begin m_b_count = 0; sb_b.delete(); end
    else m_b_count = m_b_count + int'(b_v && b_ready) - int'(b_yumi);

    check("c_count", c_count, m_c_count);
    if (c_v && c_ready) begin
      sb_c.push_back(c_data);
      if (c_win) c_fires++;
    end
    if (c_yumi) begin
      check("c_sb_nonempty", (sb_c.size() != 0), 1);
      if (sb_c.size() != 0) check("c_data", c_do, sb_c.pop_front());
    end
    if (rst) begin m_c_count = 0; sb_c.delete(); end
    else m_c_count = m_c_count + int'(c_v && c_ready) - int'(c_yumi);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int pops0;

    // Reset held three cycles while upstream offers a beat.
    a_v = 1'b1; a_data = 32'h1111;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      check("rst_ready", a_ready, 0);
      check("rst_pipe_v", a_pv, 0);
    end
    tick(); rst = 1'b0; a_v = 1'b0; #2;
    check("post_rst_v", a_vo, 0);
    check("post_rst_count", a_count, 0);
    check("post_rst_ready", a_ready, 1);
    mon = 1'b1;

    // Single beat.
    tick(); a_v = 1'b1; a_data = 32'hA5;
    tick(); a_v = 1'b0; #2 check("single_count_c1", a_count, 1);
    tick(); tick(); tick(); #2 check("single_v_c4", a_vo, 0);
    tick(); #2;
    check("single_v_c5", a_vo, 1);
    check("single_data_c5", a_do, 32'hA5);
    tick();
    tick(); a_yumi_man = 1'b1;
    tick(); a_yumi_man = 1'b0; #2;
    check("single_count_c8", a_count, 0);
    check("single_v_c8", a_vo, 0);

    // Back-pressure: 12 offers, 8 accepted.
    for (int k = 1; k <= 12; k++) begin
      tick(); a_v = 1'b1; a_data = k; #2;
      if (k == 9) check("bp_ready_off", a_ready, 0);
    end
    tick(); a_v = 1'b0;
    tick(); tick(); #2;
    check("bp_count_full", a_count, 8);
    check("bp_v", a_vo, 1);
    check("bp_sb_size", sb_a.size(), 8);
    for (int j = 1; j <= 8; j++) begin
      tick(); #2;
      if (j == 1) check("bp_ready_before_pop", a_ready, 0);
      check("bp_head", a_do, j);
      a_yumi_man = 1'b1;
      tick(); a_yumi_man = 1'b0; #2;
      check("bp_ready_back", a_ready, 1);
      if (j == 1) check("bp_count_after_pop", a_count, 7);
    end
    tick(); #2 check("bp_empty", a_vo, 0);

    // Streaming with yumi tied to v_o.
    pops0 = a_pops; a_first_pop = -1; a_max_cnt = 0;
    tick(); a_stream = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick(); a_v = 1'b1; a_data = 1000 + i; #2;
      check("stream_ready", a_ready, 1);
    end
    tick(); a_v = 1'b0;
    for (int w = 0; w < 40 && sb_a.size() != 0; w++) tick();
    check("stream_drain", sb_a.size(), 0);
    check("stream_pops", a_pops - pops0, 100);
    check("stream_contiguous", a_last_pop - a_first_pop, 99);
    check("stream_max_count_le5", (a_max_cnt <= 5), 1);
    tick(); a_stream = 1'b0;

    // Reset mid-run: 2 buffered, 3 in flight.
    for (int i = 0; i < 5; i++) begin
      tick(); a_v = 1'b1; a_data = 32'h200 + i;
    end
    tick(); a_v = 1'b0;
    tick(); #2;
    check("mid_count_before", a_count, 5);
    check("mid_v_before", a_vo, 1);
    rst = 1'b1;
    tick(); rst = 1'b0; #2;
    check("mid_v_after", a_vo, 0);
    check("mid_count_after", a_count, 0);
    check("mid_ready_after", a_ready, 1);
    for (int i = 0; i < 10; i++) begin
      tick(); #2 check("mid_no_ghost", a_vo, 0);
    end
    tick(); a_v = 1'b1; a_data = 32'h77;
    tick(); a_v = 1'b0;
    tick(); tick(); tick(); #2 check("mid_next_v_c4", a_vo, 0);
    tick(); #2;
    check("mid_next_v_c5", a_vo, 1);
    check("mid_next_data", a_do, 32'h77);
    a_yumi_man = 1'b1;
    tick(); a_yumi_man = 1'b0;

    // DUT B: random traffic across pointer wrap.
    sent = 0;
    for (int c = 0; c < 3000 && b_recv < 50; c++) begin
      tick();
      b_v    = (sent < 50) && ($urandom_range(0, 1) == 1);
      b_data = 500 + sent;
      b_yr   = ($urandom_range(0, 1) == 1);
      #2;
      if (b_v && b_ready) sent++;
    end
    tick(); b_v = 1'b0; b_yr = 1'b0; #2;
    check("b_recv", b_recv, 50);
    check("b_final_count", b_count, 0);
    check("b_sb_empty", sb_b.size(), 0);

    // DUT C: continuous traffic with a 2-entry FIFO behind a 4-stage pipe.
    sent = 0;
    for (int c = 0; c < 80; c++) begin
      tick(); c_v = 1'b1; c_data = 700 + sent; c_win = (c >= 20); #2;
      if (c_ready) sent++;
    end
    tick(); c_v = 1'b0; c_win = 1'b0;
    for (int w = 0; w < 20 && sb_c.size() != 0; w++) tick();
    check("c_drain", sb_c.size(), 0);
    check("c_tput_window", (c_fires >= 20 && c_fires <= 24), 1);
    check("c_tput_limited", (c_fires < 60), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
